// File: rtl/writeback_pkg.sv
// Shared constants and types for the register-file writeback scheduler.
// Latency: n/a (types only).  Backpressure: n/a.
package writeback_pkg;
    localparam int XLEN      = 64;
    localparam int ADDR_W    = 5;
    localparam int REG_COUNT = 32;
    localparam int MAX_WAIT  = 4;
    localparam int WAIT_W    = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_ALU  = 2'd1,
        GRANT_LOAD = 2'd2
    } grant_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;
endpackage

// File: rtl/writeback_scheduler_if.sv
// Producer, load-issue, decode and register-file signals of the writeback scheduler.
// Latency: n/a.  Backpressure: alu_ready/load_ready are the per-producer grants.
interface writeback_scheduler_if import writeback_pkg::*; ();
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              load_issue_valid;
    logic [ADDR_W-1:0] load_issue_rd;
    logic              load_valid;
    logic              load_ready;
    logic [ADDR_W-1:0] load_rd;
    logic [XLEN-1:0]   load_data;
    logic              dec_valid;
    logic [ADDR_W-1:0] dec_rs1;
    logic [ADDR_W-1:0] dec_rs2;
    logic [ADDR_W-1:0] dec_rd;
    logic              hazard_stall;
    logic              rf_reg_write;
    logic [ADDR_W-1:0] rf_rd_address;
    logic [XLEN-1:0]   rf_write_data;
    logic              rs1_fwd_valid;
    logic [XLEN-1:0]   rs1_fwd_data;
    logic              rs2_fwd_valid;
    logic [XLEN-1:0]   rs2_fwd_data;

    modport master (
        output alu_valid, alu_rd, alu_data, load_issue_valid, load_issue_rd,
               load_valid, load_rd, load_data, dec_valid, dec_rs1, dec_rs2, dec_rd,
        input  alu_ready, load_ready, hazard_stall, rf_reg_write, rf_rd_address,
               rf_write_data, rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, load_issue_valid, load_issue_rd,
               load_valid, load_rd, load_data, dec_valid, dec_rs1, dec_rs2, dec_rd,
        output alu_ready, load_ready, hazard_stall, rf_reg_write, rf_rd_address,
               rf_write_data, rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data
    );
endinterface

// File: rtl/writeback_scoreboard.sv
// Busy bit per destination register with a load in flight; three-port lookup.
// Latency: set/clear visible the cycle after the edge.  Backpressure: none.
module writeback_scoreboard import writeback_pkg::*; (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 set_vld,
    input  logic [ADDR_W-1:0]    set_rd,
    input  logic                 clr_vld,
    input  logic [ADDR_W-1:0]    clr_rd,
    input  logic [ADDR_W-1:0]    rs1,
    input  logic [ADDR_W-1:0]    rs2,
    input  logic [ADDR_W-1:0]    rd,
    output logic                 busy_rs1,
    output logic                 busy_rs2,
    output logic                 busy_rd,
    output logic [REG_COUNT-1:0] busy_vec
);
    localparam logic [REG_COUNT-1:0] X0_MASK = {{(REG_COUNT-1){1'b1}}, 1'b0};

    logic [REG_COUNT-1:0] busy;
    logic [REG_COUNT-1:0] set_mask;
    logic [REG_COUNT-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_vld) set_mask[set_rd] = 1'b1;
        if (clr_vld) clr_mask[clr_rd] = 1'b1;
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit; x0 never busy.
    always_ff @(posedge clock) begin
        if (!reset_n) busy <= '0;
        else          busy <= ((busy & ~clr_mask) | set_mask) & X0_MASK;
    end

    assign busy_rs1 = busy[rs1];
    assign busy_rs2 = busy[rs2];
    assign busy_rd  = busy[rd];
    assign busy_vec = busy;
endmodule

// File: rtl/writeback_scheduler.sv
// Arbitrates ALU vs load results onto the single RF write port; scoreboards loads; WB_BYPASS_EN adds forwarding.
// Latency: 1 cycle grant-to-write.  Backpressure: load wins unless ALU has waited MAX_WAIT cycles.
module writeback_scheduler import writeback_pkg::*; (
    input  logic                  clock,
    input  logic                  reset_n,
    writeback_scheduler_if.slave  bus
);
    logic [WAIT_W-1:0]    wait_cnt;
    grant_t               grant;
    grant_t               last_grant;
    wb_entry_t            sel;
    logic                 busy_rs1;
    logic                 busy_rs2;
    logic                 busy_rd;
    logic [REG_COUNT-1:0] busy_vec;

    always_comb begin
        grant = GRANT_NONE;
        if (reset_n) begin
            if (bus.alu_valid && (!bus.load_valid || wait_cnt == WAIT_W'(MAX_WAIT)))
                grant = GRANT_ALU;
            else if (bus.load_valid)
                grant = GRANT_LOAD;
        end
    end

    assign bus.alu_ready  = (grant == GRANT_ALU);
    assign bus.load_ready = (grant == GRANT_LOAD);

    always_comb begin
        sel = '{valid: 1'b0, rd: bus.rf_rd_address, data: bus.rf_write_data};
        case (grant)
            GRANT_ALU:  sel = '{valid: 1'b1, rd: bus.alu_rd,  data: bus.alu_data};
            GRANT_LOAD: sel = '{valid: 1'b1, rd: bus.load_rd, data: bus.load_data};
            default:    ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wait_cnt          <= '0;
            last_grant        <= GRANT_NONE;
            bus.rf_reg_write  <= 1'b0;
            bus.rf_rd_address <= '0;
            bus.rf_write_data <= '0;
        end else begin
            last_grant <= grant;
            if (bus.alu_valid && !bus.alu_ready)
                wait_cnt <= (wait_cnt == WAIT_W'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            bus.rf_reg_write  <= sel.valid && (sel.rd != '0);
            bus.rf_rd_address <= sel.rd;
            bus.rf_write_data <= sel.data;
        end
    end

    writeback_scoreboard u_scoreboard (
        .clock    (clock),
        .reset_n  (reset_n),
        .set_vld  (bus.load_issue_valid && (bus.load_issue_rd != '0)),
        .set_rd   (bus.load_issue_rd),
        .clr_vld  (bus.load_ready),
        .clr_rd   (bus.load_rd),
        .rs1      (bus.dec_rs1),
        .rs2      (bus.dec_rs2),
        .rd       (bus.dec_rd),
        .busy_rs1 (busy_rs1),
        .busy_rs2 (busy_rs2),
        .busy_rd  (busy_rd),
        .busy_vec (busy_vec)
    );

`ifdef WB_BYPASS_EN
    assign bus.rs1_fwd_valid = bus.rf_reg_write && (bus.rf_rd_address == bus.dec_rs1) && (bus.dec_rs1 != '0);
    assign bus.rs2_fwd_valid = bus.rf_reg_write && (bus.rf_rd_address == bus.dec_rs2) && (bus.dec_rs2 != '0);
    assign bus.rs1_fwd_data  = bus.rf_write_data;
    assign bus.rs2_fwd_data  = bus.rf_write_data;
    assign bus.hazard_stall  = reset_n && bus.dec_valid && (busy_rs1 || busy_rs2 || busy_rd);
`else
    // Without forwarding, a source matching the value being written now must wait one cycle.
    logic wb_hit;
    assign wb_hit = bus.rf_reg_write && (bus.rf_rd_address != '0) &&
                    ((bus.rf_rd_address == bus.dec_rs1) || (bus.rf_rd_address == bus.dec_rs2));
    assign bus.rs1_fwd_valid = 1'b0;
    assign bus.rs2_fwd_valid = 1'b0;
    assign bus.rs1_fwd_data  = '0;
    assign bus.rs2_fwd_data  = '0;
    assign bus.hazard_stall  = reset_n && bus.dec_valid && (busy_rs1 || busy_rs2 || busy_rd || wb_hit);
`endif

    always_ff @(posedge clock) begin
        if (reset_n) begin
            a_issue_busy: assert (!(bus.load_issue_valid && bus.load_issue_rd != '0) ||
                                  !busy_vec[bus.load_issue_rd] ||
                                  (bus.load_ready && bus.load_rd == bus.load_issue_rd));
            a_return_idle: assert (!bus.load_valid || bus.load_rd == '0 || busy_vec[bus.load_rd]);
            a_alu_busy: assert (!(bus.alu_valid && bus.alu_rd != '0) || !busy_vec[bus.alu_rd]);
            a_write_src: assert (!bus.rf_reg_write || last_grant != GRANT_NONE);
        end
    end
endmodule

// File: tb/tb_writeback_scheduler.sv
// Directed bench for writeback_scheduler; expectations adapt to WB_BYPASS_EN.
module tb_writeback_scheduler;
    import writeback_pkg::*;

    logic clock = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   miscompares = 0;

    writeback_scheduler_if bus ();

    writeback_scheduler dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    logic exp_wb_stall;
    logic exp_fwd;

    initial begin
`ifdef WB_BYPASS_EN
        exp_wb_stall = 1'b0;
        exp_fwd      = 1'b1;
`else
        exp_wb_stall = 1'b1;
        exp_fwd      = 1'b0;
`endif
        reset_n              = 1'b0;
        bus.alu_valid        = 1'b1;
        bus.alu_rd           = 5'd5;
        bus.alu_data         = 64'h55;
        bus.load_issue_valid = 1'b0;
        bus.load_issue_rd    = '0;
        bus.load_valid       = 1'b0;
        bus.load_rd          = '0;
        bus.load_data        = '0;
        bus.dec_valid        = 1'b0;
        bus.dec_rs1          = '0;
        bus.dec_rs2          = '0;
        bus.dec_rd           = '0;

        // Reset with an ALU result pending
        tick();
        tick();
        chk("rst_we",    bus.rf_reg_write, 0);
        chk("rst_addr",  bus.rf_rd_address, 0);
        chk("rst_data",  bus.rf_write_data, 0);
        chk("rst_aready", bus.alu_ready, 0);
        chk("rst_lready", bus.load_ready, 0);
        reset_n = 1'b1;
        #1;
        chk("post_rst_aready", bus.alu_ready, 1);
        tick();
        chk("x5_we",   bus.rf_reg_write, 1);
        chk("x5_addr", bus.rf_rd_address, 5);
        chk("x5_data", bus.rf_write_data, 64'h55);

        // ALU only
        bus.alu_rd   = 5'd7;
        bus.alu_data = 64'h1234;
        #1;
        chk("x7_aready", bus.alu_ready, 1);
        tick();
        chk("x7_we",   bus.rf_reg_write, 1);
        chk("x7_addr", bus.rf_rd_address, 7);
        chk("x7_data", bus.rf_write_data, 64'h1234);
        bus.alu_rd   = 5'd0;
        bus.alu_data = 64'h99;
        #1;
        chk("x0_aready", bus.alu_ready, 1);
        tick();
        chk("x0_we",   bus.rf_reg_write, 0);
        chk("x0_data", bus.rf_write_data, 64'h99);
        bus.alu_valid = 1'b0;
        #1;
        chk("idle_aready", bus.alu_ready, 0);
        tick();
        chk("idle_we",   bus.rf_reg_write, 0);
        chk("idle_hold", bus.rf_write_data, 64'h99);

        // Issue loads x10..x14, then contend with the ALU
        bus.load_issue_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.load_issue_rd = 5'(10 + i);
            tick();
        end
        bus.load_issue_valid = 1'b0;
        bus.alu_valid  = 1'b1;
        bus.alu_rd     = 5'd2;
        bus.alu_data   = 64'hA1;
        bus.load_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.load_rd   = (i < 4) ? 5'(10 + i) : 5'd14;
            bus.load_data = 64'h1000 + 64'(i);
            #1;
            if (i == 4) begin
                chk("force_aready", bus.alu_ready, 1);
                chk("force_lready", bus.load_ready, 0);
                tick();
                chk("force_addr", bus.rf_rd_address, 2);
                chk("force_data", bus.rf_write_data, 64'hA1);
                bus.alu_valid = 1'b0;
            end else begin
                chk("prio_lready", bus.load_ready, 1);
                chk("prio_aready", bus.alu_ready, 0);
                tick();
                chk("prio_addr", bus.rf_rd_address, (i < 4) ? 64'(10 + i) : 64'd14);
                chk("prio_data", bus.rf_write_data, 64'h1000 + 64'(i));
            end
        end
        bus.load_valid = 1'b0;

        // RAW on a load in flight
        bus.load_issue_valid = 1'b1;
        bus.load_issue_rd    = 5'd9;
        tick();
        bus.load_issue_valid = 1'b0;
        bus.dec_valid = 1'b1;
        bus.dec_rs1   = 5'd1;
        bus.dec_rs2   = 5'd9;
        bus.dec_rd    = 5'd4;
        #1;
        chk("raw_stall0", bus.hazard_stall, 1);
        tick();
        chk("raw_stall1", bus.hazard_stall, 1);
        bus.load_valid = 1'b1;
        bus.load_rd    = 5'd9;
        bus.load_data  = 64'h9999;
        #1;
        chk("raw_ret_stall", bus.hazard_stall, 1);
        chk("raw_ret_ready", bus.load_ready, 1);
        tick();
        bus.load_valid = 1'b0;
        #1;
        chk("raw_wb_stall", bus.hazard_stall, exp_wb_stall);
        chk("raw_fwd_vld",  bus.rs2_fwd_valid, exp_fwd);
        tick();
        chk("raw_clear", bus.hazard_stall, 0);

        // WAW, then same-cycle set and clear of x9
        bus.load_issue_valid = 1'b1;
        bus.load_issue_rd    = 5'd9;
        tick();
        bus.load_issue_valid = 1'b0;
        bus.dec_rs1 = 5'd0;
        bus.dec_rs2 = 5'd0;
        bus.dec_rd  = 5'd9;
        #1;
        chk("waw_stall", bus.hazard_stall, 1);
        bus.load_issue_valid = 1'b1;
        bus.load_valid       = 1'b1;
        tick();
        bus.load_issue_valid = 1'b0;
        bus.load_valid       = 1'b0;
        #1;
        chk("setclr_busy", bus.hazard_stall, 1);
        bus.dec_rd = 5'd0;
        #1;
        chk("x0_nostall", bus.hazard_stall, 0);
        bus.dec_rd     = 5'd9;
        bus.load_valid = 1'b1;
        tick();
        bus.load_valid = 1'b0;
        #1;
        chk("waw_clear", bus.hazard_stall, 0);

        // ALU write then immediate read of x3
        bus.dec_valid = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd3;
        bus.alu_data  = 64'hAA;
        tick();
        bus.alu_valid = 1'b0;
        bus.dec_valid = 1'b1;
        bus.dec_rs1   = 5'd3;
        bus.dec_rs2   = 5'd0;
        bus.dec_rd    = 5'd6;
        #1;
        chk("byp_stall",   bus.hazard_stall, exp_wb_stall);
        chk("byp_fwd_vld", bus.rs1_fwd_valid, exp_fwd);
        chk("byp_fwd_dat", bus.rs1_fwd_data, exp_fwd ? 64'hAA : 64'h0);
        chk("byp_rs2_vld", bus.rs2_fwd_valid, 0);
        tick();
        chk("byp_after", bus.hazard_stall, 0);

        // Reset discards outstanding loads
        bus.dec_valid        = 1'b0;
        bus.load_issue_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.load_issue_rd = 5'(20 + i);
            tick();
        end
        bus.load_issue_valid = 1'b0;
        bus.dec_valid = 1'b1;
        bus.dec_rs1   = 5'd20;
        bus.dec_rs2   = 5'd21;
        bus.dec_rd    = 5'd22;
        #1;
        chk("out3_stall", bus.hazard_stall, 1);
        reset_n = 1'b0;
        #1;
        chk("in_rst_stall", bus.hazard_stall, 0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("rel_stall", bus.hazard_stall, 0);
        bus.dec_rs1 = 5'd0;
        bus.dec_rs2 = 5'd21;
        bus.dec_rd  = 5'd0;
        #1;
        chk("rel_x21", bus.hazard_stall, 0);
        bus.dec_rs2 = 5'd0;
        bus.dec_rd  = 5'd22;
        #1;
        chk("rel_x22", bus.hazard_stall, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
